intdiv_req_arbiter: RTL and testbench

- Shares one intdiv_r16_plus instance among N_REQ requesters (e.g. integer pipes, vector lanes).
- Round-robin arbitration; one operation in flight at a time.
- Latches the winner's operands, drives the divider's start handshake, captures the result and returns it to the originating requester over that requester's own valid-ready response port.
- Sits between the requesters and the divider, replacing direct start/finish wiring.

---
 rtl/intdiv_req_arbiter.sv | 147 ++++++++++++++
 tb/tb_intdiv_req_arbiter.sv | 473 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/intdiv_req_arbiter.sv
// Round-robin front end sharing one intdiv_r16_plus among N_REQ requesters.
// Ports: clk/rst, flush_i; req_* request side, rsp_* response side,
// div_* divider handshake/data, busy_o/owner_o status.
module intdiv_req_arbiter #(
  parameter int  N_REQ = 4,
  parameter int  D_W   = 64,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush_i,
  input  logic [N_REQ-1:0]     req_valid_i,
  output logic [N_REQ-1:0]     req_ready_o,
  input  logic [N_REQ-1:0]     req_signed_i,
  input  logic [N_REQ*D_W-1:0] req_dividend_i,
  input  logic [N_REQ*D_W-1:0] req_divisor_i,
  output logic [N_REQ-1:0]     rsp_valid_o,
  input  logic [N_REQ-1:0]     rsp_ready_i,
  output logic [D_W-1:0]       rsp_quotient_o,
  output logic [D_W-1:0]       rsp_remainder_o,
  output logic                 rsp_divisor_is_zero_o,
  output logic                 div_start_valid_o,
  input  logic                 div_start_ready_i,
  output logic                 div_signed_op_o,
  output logic [D_W-1:0]       div_dividend_o,
  output logic [D_W-1:0]       div_divisor_o,
  output logic                 div_flush_o,
  input  logic                 div_finish_valid_i,
  output logic                 div_finish_ready_o,
  input  logic [D_W-1:0]       div_quotient_i,
  input  logic [D_W-1:0]       div_remainder_i,
  input  logic                 div_divisor_is_zero_i,
  output logic                 busy_o,
  output logic [ID_W-1:0]      owner_o
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_e;

  state_e          state_q;
  logic [ID_W-1:0] rr_ptr_q;
  logic [ID_W-1:0] owner_q;
  logic            sgn_q;
  logic [D_W-1:0]  a_q;
  logic [D_W-1:0]  b_q;
  logic [D_W-1:0]  q_q;
  logic [D_W-1:0]  r_q;
  logic            z_q;

  logic [ID_W-1:0] grant;
  logic [ID_W-1:0] nxt_ptr;
  logic            grant_vld;
  logic [ID_W:0]   idx;
  logic            accept;

  // Search from rr_ptr upward with wrap; first valid wins.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    idx       = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = {1'b0, rr_ptr_q} + (ID_W+1)'(i);
      if (idx >= (ID_W+1)'(N_REQ)) begin
        idx = idx - (ID_W+1)'(N_REQ);
      end
      if (!grant_vld && req_valid_i[idx[ID_W-1:0]]) begin
        grant_vld = 1'b1;
        grant     = idx[ID_W-1:0];
      end
    end
  end

  assign nxt_ptr = (grant == ID_W'(N_REQ-1)) ? '0 : grant + 1'b1;

  assign accept = (state_q == IDLE) && grant_vld
                && !flush_i && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      sgn_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      q_q      <= '0;
      r_q      <= '0;
      z_q      <= 1'b0;
    end else if (flush_i) begin
      state_q <= IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (grant_vld) begin
            state_q  <= ISSUE;
            owner_q  <= grant;
            rr_ptr_q <= nxt_ptr;
            sgn_q    <= req_signed_i[grant];
            a_q      <= req_dividend_i[int'(grant)*D_W +: D_W];
            b_q      <= req_divisor_i[int'(grant)*D_W +: D_W];
          end
        end
        ISSUE: begin
          if (div_start_ready_i) state_q <= WAIT;
        end
        WAIT: begin
          if (div_finish_valid_i) begin
            state_q <= RESP;
            q_q     <= div_quotient_i;
            r_q     <= div_remainder_i;
            z_q     <= div_divisor_is_zero_i;
          end
        end
        RESP: begin
          if (rsp_ready_i[owner_q]) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Handshakes are suppressed in a flush cycle so nothing
  // half-completes while the operation is being dropped.
  assign req_ready_o = accept ? (N_REQ'(1) << grant) : '0;
  assign rsp_valid_o = (state_q == RESP && !flush_i)
                     ? (N_REQ'(1) << owner_q) : '0;

  assign div_start_valid_o  = (state_q == ISSUE) && !flush_i;
  assign div_finish_ready_o = (state_q == WAIT) && !flush_i;
  assign div_flush_o        = flush_i;

  assign div_signed_op_o = sgn_q;
  assign div_dividend_o  = a_q;
  assign div_divisor_o   = b_q;

  assign rsp_quotient_o        = q_q;
  assign rsp_remainder_o       = r_q;
  assign rsp_divisor_is_zero_o = z_q;

  assign busy_o  = (state_q != IDLE);
  assign owner_o = owner_q;

endmodule

// File: tb/tb_intdiv_req_arbiter.sv
// Bench for intdiv_req_arbiter: directed vectors, corner sequences
// and random traffic against a request/response scoreboard.
module tb_intdiv_req_arbiter;

  localparam int N   = 4;
  localparam int D_W = 64;
  localparam logic [D_W-1:0] MIN = {1'b1, {(D_W-1){1'b0}}};

  logic clk = 0;
  logic rst;
  logic flush_i;
  logic [N-1:0] req_valid_i, req_ready_o, req_signed_i;
  logic [N*D_W-1:0] req_dividend_i, req_divisor_i;
  logic [N-1:0] rsp_valid_o, rsp_ready_i;
  logic [D_W-1:0] rsp_quotient_o, rsp_remainder_o;
  logic rsp_divisor_is_zero_o;
  logic div_start_valid_o, div_start_ready_i, div_signed_op_o;
  logic [D_W-1:0] div_dividend_o, div_divisor_o;
  logic div_flush_o, div_finish_valid_i, div_finish_ready_o;
  logic [D_W-1:0] div_quotient_i, div_remainder_i;
  logic div_divisor_is_zero_i, busy_o;
  logic [1:0] owner_o;

  always #5 clk = ~clk;

  intdiv_req_arbiter #(.N_REQ(N), .D_W(D_W)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_signed_i(req_signed_i),
    .req_dividend_i(req_dividend_i), .req_divisor_i(req_divisor_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_quotient_o(rsp_quotient_o), .rsp_remainder_o(rsp_remainder_o),
    .rsp_divisor_is_zero_o(rsp_divisor_is_zero_o),
    .div_start_valid_o(div_start_valid_o),
    .div_start_ready_i(div_start_ready_i),
    .div_signed_op_o(div_signed_op_o),
    .div_dividend_o(div_dividend_o), .div_divisor_o(div_divisor_o),
    .div_flush_o(div_flush_o),
    .div_finish_valid_i(div_finish_valid_i),
    .div_finish_ready_o(div_finish_ready_o),
    .div_quotient_i(div_quotient_i), .div_remainder_i(div_remainder_i),
    .div_divisor_is_zero_i(div_divisor_is_zero_i),
    .busy_o(busy_o), .owner_o(owner_o)
  );

  typedef struct packed {
    logic z;
    logic [D_W-1:0] q;
    logic [D_W-1:0] r;
  } res_t;

  typedef struct {
    int id;
    logic sgn;
    logic [D_W-1:0] a, b, q, r;
    logic z;
  } vec_t;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [511:0] act,
                     input logic [511:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tmo(input string nm, input bit ok);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got timeout expected event", nm);
    end
  endtask

  function automatic res_t ref_div(logic s, logic [D_W-1:0] a,
                                   logic [D_W-1:0] b);
    res_t o;
    logic signed [D_W-1:0] sa, sb;
    sa = a;
    sb = b;
    o.z = (b == 0);
    if (b == 0) begin
      o.q = '1; o.r = a;
    end else if (s && a == MIN && b == '1) begin
      o.q = MIN; o.r = '0;
    end else if (s) begin
      o.q = sa / sb; o.r = sa % sb;
    end else begin
      o.q = a / b; o.r = a % b;
    end
    return o;
  endfunction

  function automatic logic [N-1:0] onehot(int k);
    logic [N-1:0] o;
    o = '0;
    o[k] = 1'b1;
    return o;
  endfunction

  function automatic int first_valid(logic [N-1:0] v, int p);
    for (int i = 0; i < N; i++) begin
      if (v[(p + i) % N]) return (p + i) % N;
    end
    return -1;
  endfunction

  // Scoreboard: one operation at a time, owner, rotating pointer.
  bit m_hold = 0, m_rsp = 0;
  int m_own = 0, m_ptr = 0, cyc = 0;
  res_t m_res;
  logic [N-1:0] acc = '0;
  int gq[$], gcyc[$];
  int rsp_cnt[N] = '{default: 0};

  initial begin
    int g;
    logic [N-1:0] e_rv;
    forever begin
      @(negedge clk);
      cyc++;
      acc = req_valid_i & req_ready_o;
      chk("div_flush", div_flush_o, flush_i);
      if (rst) begin
        chk("rst_req_ready", req_ready_o, 0);
        chk("rst_rsp_valid", rsp_valid_o, 0);
        m_hold = 0; m_rsp = 0; m_ptr = 0;
      end else begin
        g = -1;
        if (!m_hold && !flush_i) g = first_valid(req_valid_i, m_ptr);
        chk("req_ready", req_ready_o, (g >= 0) ? onehot(g) : '0);
        e_rv = (m_rsp && !flush_i) ? onehot(m_own) : '0;
        chk("rsp_valid", rsp_valid_o, e_rv);
        if (e_rv != 0)
          chk("rsp_data", {rsp_divisor_is_zero_o, rsp_quotient_o,
                           rsp_remainder_o}, m_res);
        chk("busy", busy_o, m_hold);
        if (m_hold) chk("owner", owner_o, m_own);
        if (flush_i) begin
          m_hold = 0; m_rsp = 0;
        end else if (!m_hold && g >= 0) begin
          m_hold = 1; m_own = g; m_ptr = (g + 1) % N;
          m_res = ref_div(req_signed_i[g],
                          req_dividend_i[g*D_W +: D_W],
                          req_divisor_i[g*D_W +: D_W]);
          gq.push_back(g);
          gcyc.push_back(cyc);
        end else if (m_hold && !m_rsp && div_finish_valid_i
                     && div_finish_ready_o) begin
          m_rsp = 1;
        end else if (m_rsp && rsp_ready_i[m_own]) begin
          m_hold = 0; m_rsp = 0;
          rsp_cnt[m_own]++;
        end
      end
    end
  end

  // Behavioural divider with programmable latency.
  int lat_lo = 0, lat_hi = 0;
  bit stall = 0;
  initial begin
    bit d_busy, hs_s, hs_f, d_fl, p_sv, p_hs, p_fl;
    int d_cnt;
    logic [2*D_W:0] p_ops, ops;
    res_t r;
    d_busy = 0; d_cnt = 0; p_sv = 0; p_hs = 0; p_fl = 0; p_ops = '0;
    div_start_ready_i = 1; div_finish_valid_i = 0;
    div_quotient_i = '0; div_remainder_i = '0;
    div_divisor_is_zero_i = 0;
    forever begin
      @(negedge clk);
      hs_s = div_start_valid_o && div_start_ready_i;
      hs_f = div_finish_valid_i && div_finish_ready_o;
      d_fl = div_flush_o || rst;
      ops = {div_signed_op_o, div_dividend_o, div_divisor_o};
      if (div_start_valid_o && p_sv && !p_hs && !p_fl)
        chk("op_stable", ops, p_ops);
      p_sv = div_start_valid_o; p_hs = hs_s; p_fl = d_fl; p_ops = ops;
      @(posedge clk);
      #1;
      if (d_fl || hs_f) begin
        d_busy = 0;
      end else if (hs_s) begin
        d_busy = 1;
        d_cnt = int'($urandom_range(lat_hi, lat_lo));
        r = ref_div(ops[2*D_W], ops[2*D_W-1:D_W], ops[D_W-1:0]);
        div_quotient_i = r.q;
        div_remainder_i = r.r;
        div_divisor_is_zero_i = r.z;
      end else if (d_busy && d_cnt > 0) begin
        d_cnt--;
      end
      div_start_ready_i = !d_busy && !stall;
      div_finish_valid_i = d_busy && (d_cnt == 0);
    end
  end

  logic [N-1:0] pend = '0;
  logic ps[N];
  logic [D_W-1:0] pa[N], pb[N];

  function automatic logic [D_W-1:0] rand_op(bit is_div);
    case ($urandom_range(5, 0))
      0: return D_W'($urandom_range(200, 0));
      1: return D_W'({$urandom, $urandom});
      2: return MIN;
      3: return '1;
      4: return is_div ? '0 : D_W'($urandom);
      default: return -D_W'($urandom_range(50, 1));
    endcase
  endfunction

  task automatic apply_pend();
    req_valid_i = pend;
    for (int k = 0; k < N; k++) begin
      req_signed_i[k] = ps[k];
      req_dividend_i[k*D_W +: D_W] = pa[k];
      req_divisor_i[k*D_W +: D_W] = pb[k];
    end
  endtask

  task automatic drive_cycle(input int p_new, input int p_rdy,
                             input int p_fl);
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      if (acc[k]) pend[k] = 0;
      if (!pend[k] && int'($urandom_range(99, 0)) < p_new) begin
        pend[k] = 1;
        ps[k] = 1'($urandom);
        pa[k] = rand_op(0);
        pb[k] = rand_op(1);
      end
      rsp_ready_i[k] = int'($urandom_range(99, 0)) < p_rdy;
    end
    apply_pend();
    flush_i = int'($urandom_range(99, 0)) < p_fl;
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    do begin
      drive_cycle(0, 100, 0);
      n++;
    end while ((pend != 0 || busy_o) && n < 300);
    tmo("drain", pend == 0 && !busy_o);
  endtask

  task automatic issue_one(input int id, input logic s,
                           input logic [D_W-1:0] a,
                           input logic [D_W-1:0] b);
    int n;
    @(posedge clk);
    #1;
    req_valid_i = '0;
    req_valid_i[id] = 1;
    req_signed_i[id] = s;
    req_dividend_i[id*D_W +: D_W] = a;
    req_divisor_i[id*D_W +: D_W] = b;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready_o[id] && n < 50);
    tmo("issue_grant", req_ready_o[id]);
    @(posedge clk);
    #1;
    req_valid_i[id] = 0;
  endtask

  task automatic wait_rsp(input int id, input bit lat_chk);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (lat_chk && k == 1)
        chk("start_valid_t1", div_start_valid_o, 1);
    end while (!rsp_valid_o[id] && k < 200);
    tmo("rsp_wait", rsp_valid_o[id]);
    if (lat_chk) chk("rsp_latency", k, 3);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_a"}, {req_ready_o, rsp_valid_o, rsp_quotient_o,
                     rsp_remainder_o, rsp_divisor_is_zero_o}, 0);
    chk({nm, "_b"}, {div_start_valid_o, div_signed_op_o,
                     div_dividend_o, div_divisor_o, div_flush_o,
                     div_finish_ready_o, busy_o, owner_o}, 0);
  endtask

  initial begin
    vec_t tbl[6];
    int exp_g[5];
    int g, o, n, r1, r3;
    logic [D_W-1:0] eq;

    tbl[0] = '{2, 0, 64'd100, 64'd7, 64'd14, 64'd2, 0};
    tbl[1] = '{1, 1, MIN, '1, MIN, 64'd0, 0};
    tbl[2] = '{1, 0, 64'h1234, 64'd0, '1, 64'h1234, 1};
    tbl[3] = '{0, 1, -64'd7, 64'd2, -64'd3, -64'd1, 0};
    tbl[4] = '{3, 0, '1, 64'd16, 64'h0FFF_FFFF_FFFF_FFFF, 64'd15, 0};
    tbl[5] = '{3, 1, 64'd5, 64'd0, '1, 64'd5, 1};
    exp_g = '{0, 1, 2, 3, 0};

    rst = 1; flush_i = 0;
    req_valid_i = '0; req_signed_i = '0;
    req_dividend_i = '0; req_divisor_i = '0;
    rsp_ready_i = '0;
    for (int k = 0; k < N; k++) begin
      ps[k] = 0; pa[k] = '0; pb[k] = '1;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    chk_zero("reset");

    // Fairness: all requesters continuously valid from rr_ptr = 0.
    gq.delete(); gcyc.delete();
    n = 0;
    while (gq.size() < 5 && n < 100) begin
      drive_cycle(100, 100, 0);
      #1;
      n++;
    end
    tmo("fair_grants", gq.size() >= 5);
    for (int i = 0; i < 5 && i < gq.size(); i++) begin
      chk($sformatf("fair_grant%0d", i), gq[i], exp_g[i]);
      if (i > 0) chk("fair_gap", gcyc[i] - gcyc[i-1], 4);
    end
    drain();

    for (int i = 0; i < 6; i++) begin
      issue_one(tbl[i].id, tbl[i].sgn, tbl[i].a, tbl[i].b);
      wait_rsp(tbl[i].id, 1);
      chk($sformatf("vec%0d_valid", i), rsp_valid_o, onehot(tbl[i].id));
      chk($sformatf("vec%0d_q", i), rsp_quotient_o, tbl[i].q);
      chk($sformatf("vec%0d_r", i), rsp_remainder_o, tbl[i].r);
      chk($sformatf("vec%0d_z", i), rsp_divisor_is_zero_o, tbl[i].z);
      chk($sformatf("vec%0d_owner", i), owner_o, tbl[i].id);
      @(posedge clk);
      #1;
      rsp_ready_i[tbl[i].id] = 1;
      @(negedge clk);
      @(posedge clk);
      #1;
      rsp_ready_i = '0;
      @(negedge clk);
      chk($sformatf("vec%0d_idle", i), {busy_o, rsp_valid_o}, 0);
    end

    // Response back-pressure, non-owner ready ignored.
    issue_one(0, 0, 64'd1000, 64'd3);
    wait_rsp(0, 0);
    @(posedge clk);
    #1;
    req_valid_i = 4'b1110;
    rsp_ready_i = 4'b1110;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("hold_rsp", {rsp_valid_o, rsp_quotient_o, rsp_remainder_o},
          {4'b0001, 64'd333, 64'd1});
      chk("hold_idle", {req_ready_o, div_start_valid_o}, 0);
      @(posedge clk);
      #1;
    end
    req_valid_i = '0;
    rsp_ready_i = 4'b0001;
    @(negedge clk);
    @(posedge clk);
    #1;
    rsp_ready_i = '0;
    @(negedge clk);
    chk("hold_done", busy_o, 0);

    // Flush while the divider is working.
    lat_lo = 10; lat_hi = 10;
    @(posedge clk);
    #1;
    req_valid_i = 4'b1010;
    req_signed_i = '0;
    req_dividend_i[1*D_W +: D_W] = 64'd61;
    req_divisor_i[1*D_W +: D_W] = 64'd4;
    req_dividend_i[3*D_W +: D_W] = 64'd83;
    req_divisor_i[3*D_W +: D_W] = 64'd9;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (req_ready_o == 0 && n < 50);
    tmo("flush_grant", req_ready_o != 0);
    g = req_ready_o[1] ? 1 : 3;
    o = (g == 1) ? 3 : 1;
    @(posedge clk);
    #1;
    req_valid_i[g] = 0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!div_finish_ready_o && n < 50);
    tmo("flush_wait_state", div_finish_ready_o);
    @(posedge clk);
    #1;
    flush_i = 1;
    lat_lo = 0; lat_hi = 0;
    @(negedge clk);
    chk("flush_pass", {div_flush_o, rsp_valid_o}, {1'b1, 4'b0});
    @(posedge clk);
    #1;
    flush_i = 0;
    @(negedge clk);
    chk("flush_idle", {busy_o, rsp_valid_o}, 0);
    chk("flush_next_grant", req_ready_o, onehot(o));
    @(posedge clk);
    #1;
    req_valid_i = '0;
    rsp_ready_i = onehot(o);
    wait_rsp(o, 0);
    eq = (o == 1) ? 64'd15 : 64'd9;
    chk("flush_next_rsp", {rsp_valid_o, rsp_quotient_o},
        {onehot(o), eq});
    @(posedge clk);
    #1;
    rsp_ready_i = '0;

    // Reset while stuck in ISSUE.
    stall = 1;
    issue_one(1, 0, 64'd77, 64'd7);
    @(negedge clk);
    chk("rst_in_issue", div_start_valid_o, 1);
    @(posedge clk);
    #1;
    rst = 1;
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 0;
    stall = 0;
    @(negedge clk);
    chk_zero("rst_mid");
    #1;
    r1 = rsp_cnt[1];
    r3 = rsp_cnt[3];
    pend = 4'b1010;
    ps[1] = 0; pa[1] = 64'd20; pb[1] = 64'd6;
    ps[3] = 0; pa[3] = 64'd45; pb[3] = 64'd7;
    drive_cycle(0, 100, 0);
    chk("ptr_reset", req_ready_o, 4'b0010);
    drain();
    #1;
    chk("rst_rsp1", rsp_cnt[1], r1 + 1);
    chk("rst_rsp3", rsp_cnt[3], r3 + 1);

    // Random traffic with occasional flushes.
    lat_lo = 0; lat_hi = 6;
    for (int i = 0; i < 1500; i++) drive_cycle(30, 60, 2);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
